// File: rtl/rgb_to_grayscale.sv
// rgb_to_grayscale: 3-stage pipelined RGB888 -> 8-bit luma converter.
// Y = (CR*R + CG*G + CB*B + 2^(CW-1)) >> CW, saturated, with an output pixel counter.
module rgb_to_grayscale #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CW         = 8,
  parameter int unsigned CR         = 77,
  parameter int unsigned CG         = 150,
  parameter int unsigned CB         = 29,
  parameter int unsigned CNT_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] red_i,
  input  logic [DATA_WIDTH-1:0] green_i,
  input  logic [DATA_WIDTH-1:0] blue_i,
  input  logic                  done_i,
  output logic [DATA_WIDTH-1:0] grayscale_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  pix_cnt_o
);

  localparam int unsigned PW = DATA_WIDTH + CW;
  localparam int unsigned SW = DATA_WIDTH + CW + 2;
  localparam logic [SW-1:0] HALF = SW'(1) << (CW - 1);
  localparam logic [DATA_WIDTH-1:0] SAT = {DATA_WIDTH{1'b1}};

  logic [PW-1:0]         pr_q, pg_q, pb_q;
  logic [PW-1:0]         pr_d, pg_d, pb_d;
  logic                  v1_q, v2_q;
  logic [SW-1:0]         sum_q, sum_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic                  done_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Next-state datapath: weighted products, rounded sum, saturating shift, counter
  always_comb begin
    pr_d   = pr_q;
    pg_d   = pg_q;
    pb_d   = pb_q;
    sum_d  = sum_q;
    gray_d = gray_q;
    cnt_d  = cnt_q;
    if (done_i) begin
      pr_d = PW'(CR) * PW'(red_i);
      pg_d = PW'(CG) * PW'(green_i);
      pb_d = PW'(CB) * PW'(blue_i);
    end
    if (v1_q) begin
      sum_d = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + HALF;
    end
    if (v2_q) begin
      if (|sum_q[SW-1:PW]) begin
        gray_d = SAT;
      end else begin
        gray_d = sum_q[PW-1:CW];
      end
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Pipeline registers; reset discards in-flight pixels and clears the counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      v1_q   <= 1'b0;
      sum_q  <= '0;
      v2_q   <= 1'b0;
      gray_q <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pr_q   <= pr_d;
      pg_q   <= pg_d;
      pb_q   <= pb_d;
      v1_q   <= done_i;
      sum_q  <= sum_d;
      v2_q   <= v1_q;
      gray_q <= gray_d;
      done_q <= v2_q;
      cnt_q  <= cnt_d;
    end
  end

  assign grayscale_o = gray_q;
  assign done_o      = done_q;
  assign pix_cnt_o   = cnt_q;

endmodule

// File: tb/tb_rgb_to_grayscale.sv
// Directed testbench for rgb_to_grayscale (default counter and 4-bit counter instances).
module tb_rgb_to_grayscale;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] red, green, blue;
  logic       done_in;
  logic [7:0] gray;
  logic       done_out;
  logic [19:0] cnt;
  logic [7:0] gray4;
  logic       done4;
  logic [3:0] cnt4;

  int checks = 0;
  int errors = 0;
  logic [7:0]  last_gray;
  logic [19:0] exp_cnt;

  rgb_to_grayscale dut (
    .clk(clk), .rst(rst), .red_i(red), .green_i(green), .blue_i(blue),
    .done_i(done_in), .grayscale_o(gray), .done_o(done_out), .pix_cnt_o(cnt)
  );

  rgb_to_grayscale #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .red_i(red), .green_i(green), .blue_i(blue),
    .done_i(done_in), .grayscale_o(gray4), .done_o(done4), .pix_cnt_o(cnt4)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic d, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    done_in = d;
    red     = r;
    green   = g;
    blue    = b;
  endtask

  task automatic apply_reset();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    last_gray = 8'd0;
    exp_cnt   = 20'd0;
  endtask

  task automatic test_reset();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done_out !== 1'b0 || gray !== 8'd0 || cnt !== 20'd0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: done=%b gray=%0d cnt=%0d, want 0/0/0", i, done_out, gray, cnt);
      end
    end
    rst = 1'b1;
    last_gray = 8'd0;
    exp_cnt   = 20'd0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (done_out !== 1'b0 || gray !== 8'd0 || cnt !== 20'd0) begin
        errors++;
        $display("FAIL reset_release: done=%b gray=%0d cnt=%0d, want 0/0/0", done_out, gray, cnt);
      end
    end
  endtask

  task automatic test_gray_stream();
    logic ed;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      ed = (i >= 3 && i < 12);
      if (ed) begin
        last_gray = 8'(i - 2);
        exp_cnt++;
      end
      checks++;
      if (done_out !== ed || gray !== last_gray || cnt !== exp_cnt) begin
        errors++;
        $display("FAIL gray_stream slot %0d: done=%b gray=%0d cnt=%0d, want %b/%0d/%0d",
                 i, done_out, gray, cnt, ed, last_gray, exp_cnt);
      end
      if (i < 9) drive(1'b1, 8'(i + 1), 8'(i + 1), 8'(i + 1));
      else       drive(1'b0, 8'd0, 8'd0, 8'd0);
    end
    checks++;
    if (cnt !== 20'd9) begin
      errors++;
      $display("FAIL gray_stream_count: cnt=%0d want 9", cnt);
    end
  endtask

  task automatic test_primaries();
    logic [7:0] rv[5] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0};
    logic [7:0] gv[5] = '{8'd0,   8'd255, 8'd0,   8'd255, 8'd0};
    logic [7:0] bv[5] = '{8'd0,   8'd0,   8'd255, 8'd255, 8'd0};
    logic [7:0] ev[5] = '{8'd77,  8'd149, 8'd29,  8'd255, 8'd0};
    logic ed;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      ed = (i >= 3 && i < 8);
      if (ed) begin
        last_gray = ev[i - 3];
        exp_cnt++;
      end
      checks++;
      if (done_out !== ed || gray !== last_gray || cnt !== exp_cnt) begin
        errors++;
        $display("FAIL primaries slot %0d: done=%b gray=%0d cnt=%0d, want %b/%0d/%0d",
                 i, done_out, gray, cnt, ed, last_gray, exp_cnt);
      end
      if (i < 5) drive(1'b1, rv[i], gv[i], bv[i]);
      else       drive(1'b0, 8'd0, 8'd0, 8'd0);
    end
  endtask

  task automatic test_bubbles();
    logic       dv[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] pv[6] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    logic ed;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ed = (i >= 3 && i < 9) ? dv[i - 3] : 1'b0;
      if (ed) begin
        last_gray = pv[i - 3];
        exp_cnt++;
      end
      checks++;
      if (done_out !== ed || gray !== last_gray || cnt !== exp_cnt) begin
        errors++;
        $display("FAIL bubbles slot %0d: done=%b gray=%0d cnt=%0d, want %b/%0d/%0d",
                 i, done_out, gray, cnt, ed, last_gray, exp_cnt);
      end
      if (i < 6) drive(dv[i], pv[i], pv[i], pv[i]);
      else       drive(1'b0, 8'd0, 8'd0, 8'd0);
    end
  endtask

  task automatic test_reset_midstream();
    logic ed;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) drive(1'b1, 8'(100 + 50 * i), 8'(100 + 50 * i), 8'(100 + 50 * i));
      else       drive(1'b0, 8'd0, 8'd0, 8'd0);
    end
    exp_cnt++;
    checks++;
    if (done_out !== 1'b1 || gray !== 8'd100 || cnt !== exp_cnt) begin
      errors++;
      $display("FAIL midreset_pre: done=%b gray=%0d cnt=%0d, want 1/100/%0d", done_out, gray, cnt, exp_cnt);
    end
    #4 rst = 1'b0;
    #1;
    checks++;
    if (done_out !== 1'b0 || gray !== 8'd0 || cnt !== 20'd0) begin
      errors++;
      $display("FAIL midreset_async: done=%b gray=%0d cnt=%0d, want 0/0/0", done_out, gray, cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    last_gray = 8'd0;
    exp_cnt   = 20'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ed = (i == 8);
      if (ed) begin
        last_gray = 8'd90;
        exp_cnt++;
      end
      checks++;
      if (done_out !== ed || gray !== last_gray || cnt !== exp_cnt) begin
        errors++;
        $display("FAIL midreset_after slot %0d: done=%b gray=%0d cnt=%0d, want %b/%0d/%0d",
                 i, done_out, gray, cnt, ed, last_gray, exp_cnt);
      end
      if (i == 5) drive(1'b1, 8'd90, 8'd90, 8'd90);
      else        drive(1'b0, 8'd0, 8'd0, 8'd0);
    end
  endtask

  task automatic test_counter_wrap();
    logic ed;
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      ed = (i >= 3 && i < 20);
      if (ed) exp_cnt++;
      checks++;
      if (done4 !== ed || cnt4 !== exp_cnt[3:0] || cnt !== exp_cnt) begin
        errors++;
        $display("FAIL counter_wrap slot %0d: done4=%b cnt4=%0d cnt=%0d, want %b/%0d/%0d",
                 i, done4, cnt4, cnt, ed, exp_cnt[3:0], exp_cnt);
      end
      if (i < 17) drive(1'b1, 8'(i + 1), 8'(i + 1), 8'(i + 1));
      else        drive(1'b0, 8'd0, 8'd0, 8'd0);
    end
    checks++;
    if (cnt4 !== 4'd1) begin
      errors++;
      $display("FAIL counter_wrap_final: cnt4=%0d want 1", cnt4);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    last_gray = 8'd0;
    exp_cnt   = 20'd0;
    test_reset();
    test_gray_stream();
    test_primaries();
    test_bubbles();
    test_reset_midstream();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
